// File: rtl/reg_file.sv
// Register file with two registered read ports and one write port.
// Reads are write-first, register 0 reads as zero, and writes are counted.
module reg_file #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic              re,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic [15:0]       wr_count
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];

  logic              commit_c;
  logic              fwd1_c;
  logic              fwd2_c;
  logic [DATA_W-1:0] rdata1_c;
  logic [DATA_W-1:0] rdata2_c;

  // Entry 0 is never written, so reading it always yields zero.
  always_comb begin
    commit_c = 1'b0;
    fwd1_c   = 1'b0;
    fwd2_c   = 1'b0;
    commit_c = we && (wa != '0);
    fwd1_c   = commit_c && (wa == ra1);
    fwd2_c   = commit_c && (wa == ra2);
    rdata1_c = fwd1_c ? wd : regs[ra1];
    rdata2_c = fwd2_c ? wd : regs[ra2];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regs     <= '{default: '0};
      rd1      <= '0;
      rd2      <= '0;
      wr_count <= '0;
    end else begin
      if (commit_c) begin
        regs[wa] <= wd;
        wr_count <= wr_count + 16'd1;
      end
      if (re) begin
        rd1 <= rdata1_c;
        rd2 <= rdata2_c;
      end
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed vector table, counter wrap,
// and a model-driven random phase, all checked through a scoreboard queue.
module tb_reg_file;

  logic        clk = 1'b0;
  logic        rst, we, re;
  logic [4:0]  wa, ra1, ra2;
  logic [31:0] wd, rd1, rd2;
  logic [15:0] wr_count;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        rst;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        re;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] e1;
    logic [31:0] e2;
    logic [15:0] ec;
  } vec_t;

  typedef struct {
    logic [31:0] e1;
    logic [31:0] e2;
    logic [15:0] ec;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[17];

  reg_file #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd), .re(re),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare after the edge.
  task automatic step(input string name, input vec_t v);
    exp_t e;
    @(negedge clk);
    rst = v.rst; we = v.we; wa = v.wa; wd = v.wd;
    re = v.re; ra1 = v.ra1; ra2 = v.ra2;
    sb.push_back('{v.e1, v.e2, v.ec});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check32({name, ".rd1"}, rd1, e.e1);
    check32({name, ".rd2"}, rd2, e.e2);
    check32({name, ".wr_count"}, {16'h0, wr_count}, {16'h0, e.ec});
  endtask

  logic [31:0] mem [32];
  logic [31:0] m_rd1, m_rd2;
  logic [15:0] m_cnt;

  initial begin
    vec_t v;
    // rst we wa wd re ra1 ra2 | rd1 rd2 wr_count
    tbl[0]  = '{1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0, 16'd0};
    tbl[1]  = '{1'b1, 1'b1, 5'd2, 32'h5, 1'b1, 5'd2, 5'd2, 32'h0, 32'h0, 16'd0};
    tbl[2]  = '{1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd31, 32'h0, 32'h0, 16'd0};
    tbl[3]  = '{1'b0, 1'b1, 5'd8, 32'hFFFFFFF8, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0, 16'd1};
    tbl[4]  = '{1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd8, 5'd0, 32'hFFFFFFF8, 32'h0, 16'd1};
    tbl[5]  = '{1'b0, 1'b1, 5'd0, 32'hDEADBEEF, 1'b1, 5'd0, 5'd8, 32'h0, 32'hFFFFFFF8, 16'd1};
    tbl[6]  = '{1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd8, 5'd0, 32'hFFFFFFF8, 32'h0, 16'd1};
    tbl[7]  = '{1'b0, 1'b1, 5'd3, 32'h11, 1'b0, 5'd0, 5'd0, 32'hFFFFFFF8, 32'h0, 16'd2};
    tbl[8]  = '{1'b0, 1'b1, 5'd3, 32'h22, 1'b1, 5'd3, 5'd3, 32'h22, 32'h22, 16'd3};
    tbl[9]  = '{1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd8, 32'h22, 32'hFFFFFFF8, 16'd3};
    tbl[10] = '{1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd8, 5'd5, 32'h22, 32'hFFFFFFF8, 16'd3};
    tbl[11] = '{1'b0, 1'b1, 5'd5, 32'h80000000, 1'b0, 5'd1, 5'd2, 32'h22, 32'hFFFFFFF8, 16'd4};
    tbl[12] = '{1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd3, 32'h80000000, 32'h22, 16'd4};
    tbl[13] = '{1'b0, 1'b1, 5'd7, 32'hA5A5A5A5, 1'b1, 5'd7, 5'd0, 32'hA5A5A5A5, 32'h0, 16'd5};
    tbl[14] = '{1'b0, 1'b1, 5'd9, 32'h1234, 1'b1, 5'd8, 5'd9, 32'hFFFFFFF8, 32'h1234, 16'd6};
    tbl[15] = '{1'b1, 1'b1, 5'd4, 32'h7, 1'b1, 5'd5, 5'd3, 32'h0, 32'h0, 16'd0};
    tbl[16] = '{1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 5'd5, 32'h0, 32'h0, 16'd0};

    rst = 1'b1; we = 1'b0; re = 1'b0; wa = '0; wd = '0; ra1 = '0; ra2 = '0;

    for (int i = 0; i < 17; i++) step($sformatf("vec%0d", i), tbl[i]);

    // No dead cycle after reset: write and forward on the first edge.
    step("post_rst", '{1'b0, 1'b1, 5'd4, 32'h7, 1'b1, 5'd4, 5'd8, 32'h7, 32'h0, 16'd1});

    // Counter wrap: 65536 writes to address 1 bring wr_count back to 0.
    step("wrap_rst", '{1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0, 16'd0});
    for (int i = 0; i < 65536; i++) begin
      v = '{1'b0, 1'b1, 5'd1, 32'h80000000 | 32'(i), 1'b0, 5'd0, 5'd0,
            32'h0, 32'h0, 16'(i + 1)};
      step("wrap", v);
    end
    step("wrap_read", '{1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd1, 5'd0, 32'h8000FFFF, 32'h0, 16'd0});

    // Random traffic against a behavioural model.
    step("rnd_rst", '{1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0, 16'd0});
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    m_rd1 = 32'h0; m_rd2 = 32'h0; m_cnt = 16'h0;
    for (int i = 0; i < 300; i++) begin
      v.rst = 1'b0;
      v.we  = 1'($urandom_range(0, 1));
      v.wa  = 5'($urandom_range(0, 7));
      v.wd  = $urandom;
      v.re  = ($urandom_range(0, 3) != 0);
      v.ra1 = 5'($urandom_range(0, 7));
      v.ra2 = 5'($urandom_range(0, 7));
      if (v.re) begin
        m_rd1 = (v.we && v.wa != 5'd0 && v.wa == v.ra1) ? v.wd : mem[v.ra1];
        m_rd2 = (v.we && v.wa != 5'd0 && v.wa == v.ra2) ? v.wd : mem[v.ra2];
      end
      if (v.we && v.wa != 5'd0) begin
        mem[v.wa] = v.wd;
        m_cnt = m_cnt + 16'd1;
      end
      v.e1 = m_rd1; v.e2 = m_rd2; v.ec = m_cnt;
      step("rnd", v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 Parameter DATA_W, default 32: width of every register and of each data port.
REQ-002 Parameter ADDR_W, default 5: register address width; the file holds 2**ADDR_W registers.
REQ-003 The block SHALL be clocked by a single clock, and reset SHALL be synchronous and active-high.
REQ-004 clk  input  1: sole clock; all state updates on rising edge.
REQ-005 rst  input  1: synchronous, active-high reset.
REQ-006 we  input  1: write enable for the writeback port.
REQ-007 wa  input  ADDR_W: write address (RegDst-selected destination).
REQ-008 wd  input  DATA_W: write data (MemtoReg-selected result).
REQ-009 re  input  1: read enable; when low, rd1/rd2 hold their previous values.
REQ-010 ra1  input  ADDR_W: read address, port 1 (rs).
REQ-011 ra2  input  ADDR_W: read address, port 2 (rt).
REQ-012 rd1  output  DATA_W: registered read data, port 1.
REQ-013 rd2  output  DATA_W: registered read data, port 2.
REQ-014 wr_count  output  16: count of committed writes since reset, for debug and verification.

Function
REQ-015 Storage SHALL be 2**ADDR_W registers of DATA_W bits.
REQ-016 Register 0 SHALL always read as 0; writes to address 0 SHALL be discarded and SHALL NOT increment wr_count.
REQ-017 A write SHALL commit on the rising edge where we=1, rst=0 and wa!=0, so that reg[wa] becomes wd.
REQ-018 Read latency SHALL be 1 cycle: on an edge with re=1, rd1 becomes the value of reg[ra1] and rd2 becomes the value of reg[ra2].
REQ-019 Same-cycle read and write to the same nonzero address SHALL be write-first: rd returns wd, not the old contents.
REQ-020 Forwarding SHALL apply independently to each port, so ra1=ra2=wa yields wd on both ports.
REQ-021 A write to address 0 in the same cycle as a read of address 0 SHALL return 0 on that port.
REQ-022 With re=0, rd1/rd2 SHALL hold; a write still commits, and later reads SHALL see it.
REQ-023 wr_count SHALL increment by 1 per committed write and SHALL wrap from 0xFFFF to 0x0000.
REQ-024 Data and address SHALL be stored and passed bit-exact, with no sign extension or truncation, including values with the MSB set.
REQ-025 X/Z values on we or re SHALL NOT be required to be handled; the testbench SHALL drive known values.

Reset
REQ-026 On an edge with rst=1, all registers, rd1, rd2 and wr_count SHALL become 0.
REQ-027 rst SHALL take priority over a simultaneous we or re: no write commits and reads return 0.
REQ-028 On the first edge after rst deasserts, normal operation SHALL resume with no dead cycle.
REQ-029 Before the first reset, outputs SHALL be unspecified; the testbench SHALL assert rst for at least 1 cycle.

Verification
REQ-030 Reset then read: rst for 2 cycles, then re=1 with ra1=5 and ra2=31 -> next cycle rd1=0, rd2=0, wr_count=0.
REQ-031 Write then read: we=1, wa=8, wd=0xFFFFFFF8 for one cycle, then re=1, ra1=8 -> rd1=0xFFFFFFF8, wr_count=1.
REQ-032 Zero register: we=1, wa=0, wd=0xDEADBEEF, re=1, ra1=0 in the same cycle, then read ra2=0 -> rd1=0, rd2=0, wr_count unchanged.
REQ-033 Forwarding: reg[3]=0x11 preloaded, then in one cycle we=1, wa=3, wd=0x22, re=1, ra1=3, ra2=3 -> rd1=0x22, rd2=0x22.
REQ-034 Hold and mid-operation reset: re=0 with ra1 changing -> rd1 stable; then rst=1 with we=1, wa=4, wd=7 -> reg[4]=0, rd1=0, wr_count=0.
REQ-035 Counter wrap: perform 65536 writes to address 1 -> wr_count=0, and reg[1] holds the last written value.
